// File: rtl/sram_device_responder_if.sv
// Controller-to-device SRAM control pins (address, chip/output/write enables, byte lanes).
interface sram_device_responder_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [ADDR_W-1:0] address_in;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              lb_n;
  logic              ub_n;

  modport master (output address_in, ce_n, oe_n, we_n, lb_n, ub_n);
  modport slave  (input  address_in, ce_n, oe_n, we_n, lb_n, ub_n);
endinterface

// File: rtl/sram_device_responder.sv
// Cycle-based device end of an asynchronous 16-bit SRAM: reads answer after a
// programmable access latency, writes commit when the write pulse ends, with
// per-byte masking. The shared data bus stays a plain inout next to the pin bundle.
module sram_device_responder #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned MEM_AW         = 10,
  parameter int unsigned READ_LATENCY   = 11,
  parameter int unsigned RELEASE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_device_responder_if.slave bus,
  inout  wire  [DATA_W-1:0]      dq,
  output logic                   protocol_err,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
);

  localparam int unsigned LANE_W = DATA_W / 2;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned REL_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_RELEASE,
    ST_WRITE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [REL_W-1:0]  r_rel_cnt;
  logic              r_drv_lb;
  logic              r_drv_ub;
  logic [DATA_W-1:0] r_dq_out;
  logic [15:0]       r_rd_count;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_lb;
  logic              r_wr_ub;
  logic              r_protocol_err;
  logic [15:0]       r_wr_count;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr;
  logic              w_rd;
  logic              w_addr_chg;
  logic              w_commit;
  logic [DATA_W-1:0] w_mem_word;

  // Pin decode: a low we_n with the chip selected is always a write, regardless of oe_n.
  assign w_wr       = ~bus.ce_n & ~bus.we_n;
  assign w_rd       = ~bus.ce_n & ~bus.oe_n & bus.we_n;
  assign w_addr_chg = (bus.address_in != r_addr);
  assign w_commit   = (r_state == ST_WRITE) & ~w_wr;
  assign w_mem_word = r_mem[r_addr[MEM_AW-1:0]];

  // Per-lane tristate; drive enables come straight from flops so reset releases dq at once.
  assign dq[LANE_W-1:0]      = r_drv_lb ? r_dq_out[LANE_W-1:0]      : {LANE_W{1'bz}};
  assign dq[DATA_W-1:LANE_W] = r_drv_ub ? r_dq_out[DATA_W-1:LANE_W] : {(DATA_W-LANE_W){1'bz}};

  assign protocol_err = r_protocol_err;
  assign rd_count     = r_rd_count;
  assign wr_count     = r_wr_count;

  // Access sequencer: read latency, data-drive and release windows, write entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_lat_cnt  <= '0;
      r_rel_cnt  <= '0;
      r_drv_lb   <= 1'b0;
      r_drv_ub   <= 1'b0;
      r_dq_out   <= '0;
      r_rd_count <= '0;
    end else begin
      r_drv_lb <= 1'b0;
      r_drv_ub <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr) begin
            r_state <= ST_WRITE;
          end else if (w_rd) begin
            r_state   <= ST_RD_WAIT;
            r_addr    <= bus.address_in;
            r_lat_cnt <= '0;
          end
        end
        ST_RD_WAIT: begin
          if (w_wr) begin
            r_state <= ST_WRITE;
          end else if (!w_rd) begin
            r_state <= ST_IDLE;
          end else if (w_addr_chg) begin
            r_addr    <= bus.address_in;
            r_lat_cnt <= '0;
          end else if (r_lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
            r_state    <= ST_RD_DRIVE;
            r_drv_lb   <= ~bus.lb_n;
            r_drv_ub   <= ~bus.ub_n;
            r_dq_out   <= w_mem_word;
            r_rd_count <= r_rd_count + 16'd1;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        ST_RD_DRIVE: begin
          if (w_wr) begin
            r_state <= ST_WRITE;
          end else if (!w_rd) begin
            if (RELEASE_CYCLES != 0) begin
              r_state   <= ST_RELEASE;
              r_rel_cnt <= '0;
              r_drv_lb  <= r_drv_lb;
              r_drv_ub  <= r_drv_ub;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_addr_chg) begin
            r_state   <= ST_RD_WAIT;
            r_addr    <= bus.address_in;
            r_lat_cnt <= '0;
          end else begin
            r_drv_lb <= ~bus.lb_n;
            r_drv_ub <= ~bus.ub_n;
            r_dq_out <= w_mem_word;
          end
        end
        ST_RELEASE: begin
          if (w_wr) begin
            r_state <= ST_WRITE;
          end else if (w_rd) begin
            r_state   <= ST_RD_WAIT;
            r_addr    <= bus.address_in;
            r_lat_cnt <= '0;
          end else if (r_rel_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_rel_cnt <= r_rel_cnt + REL_W'(1);
            r_drv_lb  <= r_drv_lb;
            r_drv_ub  <= r_drv_ub;
          end
        end
        ST_WRITE: begin
          if (w_wr) begin
            r_state <= ST_WRITE;
          end else if (w_rd) begin
            r_state   <= ST_RD_WAIT;
            r_addr    <= bus.address_in;
            r_lat_cnt <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write pulse tracking: snapshot pins every active cycle, flag address slips, count commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_wr_lb        <= 1'b0;
      r_wr_ub        <= 1'b0;
      r_protocol_err <= 1'b0;
      r_wr_count     <= '0;
    end else begin
      if (w_wr) begin
        r_wr_addr <= bus.address_in;
        r_wr_data <= dq;
        r_wr_lb   <= ~bus.lb_n;
        r_wr_ub   <= ~bus.ub_n;
      end
      if ((r_state == ST_WRITE) && w_wr && (bus.address_in != r_wr_addr)) begin
        r_protocol_err <= 1'b1;
      end
      if (w_commit) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  // Storage array (not reset): commit the last snapshot of the pulse, enabled bytes only.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (r_wr_lb) begin
        r_mem[r_wr_addr[MEM_AW-1:0]][LANE_W-1:0] <= r_wr_data[LANE_W-1:0];
      end
      if (r_wr_ub) begin
        r_mem[r_wr_addr[MEM_AW-1:0]][DATA_W-1:LANE_W] <= r_wr_data[DATA_W-1:LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_sram_device_responder.sv
// Directed + randomized bench for sram_device_responder with a word-array reference model.
module tb_sram_device_responder;

  localparam int unsigned RL = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  wire  [15:0] dq;
  logic [15:0] tb_dq;
  logic        tb_drv;
  logic        protocol_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image, expected counters and sticky error flag.
  logic [15:0] model_mem [1024];
  int          exp_rd;
  int          exp_wr;
  logic        exp_err;

  sram_device_responder_if #(.ADDR_W(18)) bus ();

  sram_device_responder #(
    .DATA_W(16), .ADDR_W(18), .MEM_AW(10), .READ_LATENCY(RL), .RELEASE_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dq(dq),
    .protocol_err(protocol_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  assign dq = tb_drv ? tb_dq : 16'hzzzz;

  always #5 clk = ~clk;

  // A released lane reads Z on four-state simulators and 0 on two-state ones;
  // stored bytes are always nonzero so 0 means "not driven".
  function automatic logic [7:0] lane_norm(input logic [7:0] v);
    return (v === 8'hzz) ? 8'h00 : v;
  endfunction

  function automatic logic [15:0] bus_norm();
    return {lane_norm(dq[15:8]), lane_norm(dq[7:0])};
  endfunction

  function automatic logic [15:0] exp_word(input logic [17:0] addr, input bit lb_on, input bit ub_on);
    logic [15:0] w;
    w = model_mem[addr[9:0]];
    return {ub_on ? w[15:8] : 8'h00, lb_on ? w[7:0] : 8'h00};
  endfunction

  function automatic logic [15:0] rnd_word();
    return {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
  endfunction

  function automatic void model_write(input logic [17:0] addr, input logic [15:0] d,
                                      input bit lb_on, input bit ub_on);
    if (lb_on) model_mem[addr[9:0]][7:0]  = d[7:0];
    if (ub_on) model_mem[addr[9:0]][15:8] = d[15:8];
    exp_wr++;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, " rd_count"}, rd_count, 16'(exp_rd));
    chk({tag, " wr_count"}, wr_count, 16'(exp_wr));
    chk({tag, " protocol_err"}, {15'd0, protocol_err}, {15'd0, exp_err});
  endtask

  task automatic idle_pins();
    bus.ce_n = 1'b1;
    bus.oe_n = 1'b1;
    bus.we_n = 1'b1;
    tb_drv   = 1'b0;
  endtask

  // Full write pulse of plen cycles, then deselect; checks the commit count afterwards.
  task automatic do_write(input string tag, input logic [17:0] addr, input logic [15:0] d,
                          input bit lb_on, input bit ub_on, input int plen);
    @(negedge clk);
    bus.address_in = addr;
    bus.ce_n = 1'b0; bus.oe_n = 1'b1; bus.we_n = 1'b0;
    bus.lb_n = ~lb_on; bus.ub_n = ~ub_on;
    tb_dq = d; tb_drv = 1'b1;
    repeat (plen - 1) @(negedge clk);
    @(negedge clk);
    idle_pins();
    model_write(addr, d, lb_on, ub_on);
    @(negedge clk);
    chk({tag, " wr_count"}, wr_count, 16'(exp_wr));
    chk({tag, " bus idle"}, bus_norm(), 16'h0000);
  endtask

  task automatic start_read(input logic [17:0] addr, input bit lb_on, input bit ub_on);
    @(negedge clk);
    bus.address_in = addr;
    bus.ce_n = 1'b0; bus.oe_n = 1'b0; bus.we_n = 1'b1;
    bus.lb_n = ~lb_on; bus.ub_n = ~ub_on;
    tb_drv = 1'b0;
  endtask

  // Pins were set stable at the previous negedge: RL released cycles, then the data.
  task automatic observe_read(input string tag, input logic [17:0] addr,
                              input bit lb_on, input bit ub_on);
    for (int i = 0; i < int'(RL); i++) begin
      @(negedge clk);
      chk({tag, " wait"}, bus_norm(), 16'h0000);
    end
    @(negedge clk);
    exp_rd++;
    chk({tag, " data"}, bus_norm(), exp_word(addr, lb_on, ub_on));
    chk({tag, " rd_count"}, rd_count, 16'(exp_rd));
  endtask

  // Deselect: one more cycle of the last data, then released.
  task automatic end_read(input string tag, input logic [15:0] last);
    @(negedge clk);
    bus.ce_n = 1'b1; bus.oe_n = 1'b1;
    @(negedge clk);
    chk({tag, " hold"}, bus_norm(), last);
    @(negedge clk);
    chk({tag, " released"}, bus_norm(), 16'h0000);
  endtask

  initial begin
    logic [15:0] wd;
    logic [17:0] a;
    bit          lb;
    bit          ub;

    rst_n = 1'b0;
    bus.address_in = '0;
    bus.lb_n = 1'b0; bus.ub_n = 1'b0;
    tb_dq = '0;
    idle_pins();
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset bus", bus_norm(), 16'h0000);
    chk_status("reset");
    rst_n = 1'b1;

    // Full write then read back after the access latency.
    do_write("t1 wr", 18'h00010, 16'hA5C3, 1'b1, 1'b1, 3);
    start_read(18'h00010, 1'b1, 1'b1);
    observe_read("t1 rd", 18'h00010, 1'b1, 1'b1);
    chk("t1 value", bus_norm(), 16'hA5C3);
    chk_status("t1");
    end_read("t1 end", exp_word(18'h00010, 1'b1, 1'b1));

    // Upper-byte write merges; lane enables act per cycle while driving.
    do_write("t2 wr", 18'h00010, 16'h12FF, 1'b0, 1'b1, 2);
    start_read(18'h00010, 1'b1, 1'b1);
    observe_read("t2 rd", 18'h00010, 1'b1, 1'b1);
    chk("t2 value", bus_norm(), 16'h12C3);
    end_read("t2 end", exp_word(18'h00010, 1'b1, 1'b1));
    start_read(18'h00010, 1'b0, 1'b1);
    observe_read("t2 ub only", 18'h00010, 1'b0, 1'b1);
    @(negedge clk); bus.lb_n = 1'b0;
    @(negedge clk);
    chk("t2 lb on", bus_norm(), exp_word(18'h00010, 1'b1, 1'b1));
    end_read("t2 lb end", exp_word(18'h00010, 1'b1, 1'b1));

    // Address change during the latency window restarts the access.
    do_write("t3 wr", 18'h00011, rnd_word(), 1'b1, 1'b1, 2);
    start_read(18'h00010, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3 early wait", bus_norm(), 16'h0000);
    end
    bus.address_in = 18'h00011;
    observe_read("t3 rd", 18'h00011, 1'b1, 1'b1);
    chk_status("t3");
    end_read("t3 end", exp_word(18'h00011, 1'b1, 1'b1));

    // Address slips mid-pulse: sticky error; the pulse's final address is what commits.
    wd = rnd_word();
    @(negedge clk);
    bus.address_in = 18'h00020;
    bus.ce_n = 1'b0; bus.oe_n = 1'b1; bus.we_n = 1'b0; bus.lb_n = 1'b0; bus.ub_n = 1'b0;
    tb_dq = wd; tb_drv = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.address_in = 18'h00021;
    @(negedge clk);
    @(negedge clk); idle_pins();
    model_write(18'h00021, wd, 1'b1, 1'b1);
    exp_err = 1'b1;
    @(negedge clk);
    chk_status("t4 slip");
    do_write("t4 alias wr", 18'h00400, rnd_word(), 1'b1, 1'b1, 2);
    start_read(18'h00000, 1'b1, 1'b1);
    observe_read("t4 alias rd", 18'h00000, 1'b1, 1'b1);
    end_read("t4 alias end", exp_word(18'h00000, 1'b1, 1'b1));
    start_read(18'h00021, 1'b1, 1'b1);
    observe_read("t4 slip rd", 18'h00021, 1'b1, 1'b1);
    end_read("t4 slip end", exp_word(18'h00021, 1'b1, 1'b1));
    chk_status("t4 sticky");

    // OE and WE both low: never driven, write commits, then the read sees new data.
    @(negedge clk);
    bus.address_in = 18'h00011;
    bus.ce_n = 1'b0; bus.oe_n = 1'b0; bus.we_n = 1'b0; bus.lb_n = 1'b0; bus.ub_n = 1'b0;
    tb_drv = 1'b0;
    for (int i = 0; i < int'(RL) + 2; i++) begin
      @(negedge clk);
      chk("t5 no drive", bus_norm(), 16'h0000);
    end
    wd = rnd_word();
    tb_dq = wd; tb_drv = 1'b1;
    @(negedge clk);
    bus.we_n = 1'b1; tb_drv = 1'b0;
    model_write(18'h00011, wd, 1'b1, 1'b1);
    observe_read("t5 rd after wr", 18'h00011, 1'b1, 1'b1);
    chk_status("t5");
    end_read("t5 end", exp_word(18'h00011, 1'b1, 1'b1));

    // Asynchronous reset while driving; memory survives.
    start_read(18'h00021, 1'b1, 1'b1);
    observe_read("t6 rd", 18'h00021, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("t6 async release", bus_norm(), 16'h0000);
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
    idle_pins();
    @(negedge clk);
    chk_status("t6 reset");
    rst_n = 1'b1;
    start_read(18'h00021, 1'b1, 1'b1);
    observe_read("t6 reread", 18'h00021, 1'b1, 1'b1);
    end_read("t6 end", exp_word(18'h00021, 1'b1, 1'b1));

    // Randomized traffic over a small aliased pool.
    for (int k = 0; k < 8; k++) begin
      a = {8'($urandom), 10'(256 + 3 * k)};
      do_write("pool init", a, rnd_word(), 1'b1, 1'b1, int'($urandom_range(1, 4)));
    end
    for (int n = 0; n < 24; n++) begin
      a  = {8'($urandom), 10'(256 + 3 * int'($urandom_range(0, 7)))};
      lb = 1'($urandom_range(0, 1));
      ub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        do_write("rnd wr", a, rnd_word(), lb, ub, int'($urandom_range(1, 4)));
      end else begin
        start_read(a, lb, ub);
        observe_read("rnd rd", a, lb, ub);
        end_read("rnd end", exp_word(a, lb, ub));
      end
    end
    chk_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
